// File: rtl/alu_rot_pkg.sv
// Shared definitions for the pipelined rotate/shift unit: op encoding and the
// amount reduction used by both the datapath and its reference model.
package alu_rot_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_ROL = 3'd0;
    localparam op_t OP_ROR = 3'd1;
    localparam op_t OP_SHL = 3'd2;
    localparam op_t OP_SHR = 3'd3;
    localparam op_t OP_ASR = 3'd4;

    // Amounts are $clog2(w) bits wide, so they never reach 2*w and a single
    // conditional subtract is a complete mod-w reduction.
    function automatic int unsigned mod_w(input int unsigned n, input int unsigned w);
        return (n >= w) ? n - w : n;
    endfunction

endpackage

// File: rtl/alu_rot_stage.sv
// One conditional barrel stage: moves the word by DIST positions when enabled,
// direction and fill chosen by the op code.
module alu_rot_stage
    import alu_rot_pkg::*;
#(
    parameter int unsigned W    = 7,
    parameter int unsigned DIST = 1
) (
    input  logic [W-1:0] d_in,
    input  logic         en,
    input  op_t          op,
    input  logic         fill,
    output logic [W-1:0] d_out
);

    always_comb begin
        d_out = d_in;
        if (en) begin
            case (op)
                OP_ROL:         d_out = {d_in[W-DIST-1:0], d_in[W-1:W-DIST]};
                OP_ROR:         d_out = {d_in[DIST-1:0], d_in[W-1:DIST]};
                OP_SHL:         d_out = {d_in[W-DIST-1:0], {DIST{1'b0}}};
                OP_SHR, OP_ASR: d_out = {{DIST{fill}}, d_in[W-1:DIST]};
                default:        d_out = d_in;
            endcase
        end
    end

endmodule

// File: rtl/alu_rot_pipe.sv
// Two-stage valid/ready rotate/shift unit (ROL/ROR/SHL/SHR/ASR), 2-cycle latency.
// Optional carry/zero flags are enabled by defining ALU_ROT_FLAGS_EN.
module alu_rot_pipe
    import alu_rot_pkg::*;
#(
    parameter  int unsigned W  = 7,
    localparam int unsigned NW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [NW-1:0] in_n,
    input  op_t           in_op,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef ALU_ROT_FLAGS_EN
    output logic          out_c,
    output logic          out_z,
`endif
    output logic [W-1:0]  out_r
);

    logic          s1_valid_q, s1_valid_d;
    logic [W-1:0]  s1_a_q, s1_a_d;
    op_t           s1_op_q, s1_op_d;
    logic [NW-1:0] s1_n_q, s1_n_d;
    logic          s1_sat_q, s1_sat_d;

    logic          s2_valid_q, s2_valid_d;
    logic [W-1:0]  s2_r_q, s2_r_d;

    logic          s1_en, s2_en;
    logic          fill;
    logic [W-1:0]  result;
    logic [NW:0][W-1:0] stg;

    assign s2_en    = !s2_valid_q || out_ready;
    assign s1_en    = !s1_valid_q || s2_en;
    assign in_ready = s1_en;

    // Reserved ops and saturated shifts leave the amount at zero so the
    // barrel passes the operand straight through.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_op_d    = s1_op_q;
        s1_n_d     = s1_n_q;
        s1_sat_d   = s1_sat_q;
        if (s1_en) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d   = in_a;
                s1_op_d  = in_op;
                s1_n_d   = '0;
                s1_sat_d = 1'b0;
                case (in_op)
                    OP_ROL, OP_ROR: s1_n_d = NW'(mod_w(32'(in_n), W));
                    OP_SHL, OP_SHR, OP_ASR: begin
                        if (32'(in_n) >= W) s1_sat_d = 1'b1;
                        else                s1_n_d   = in_n;
                    end
                    default: s1_n_d = '0;
                endcase
            end
        end
    end

    assign fill   = (s1_op_q == OP_ASR) ? s1_a_q[W-1] : 1'b0;
    assign stg[0] = s1_a_q;

    for (genvar k = 0; k < NW; k++) begin : g_stage
        alu_rot_stage #(.W(W), .DIST(2**k)) u_stage (
            .d_in  (stg[k]),
            .en    (s1_n_q[k]),
            .op    (s1_op_q),
            .fill  (fill),
            .d_out (stg[k+1])
        );
    end

    always_comb begin
        result = stg[NW];
        if (s1_sat_q) begin
            case (s1_op_q)
                OP_ASR:  result = {W{s1_a_q[W-1]}};
                default: result = '0;
            endcase
        end
    end

`ifdef ALU_ROT_FLAGS_EN
    logic          s2_c_q, s2_c_d;
    logic          s2_z_q, s2_z_d;
    logic          carry;
    logic [NW-1:0] idx_l, idx_r;
    logic          n_nz;

    assign n_nz  = |s1_n_q;
    assign idx_l = NW'(W - 32'(s1_n_q));
    assign idx_r = s1_n_q - NW'(1);

    always_comb begin
        carry = 1'b0;
        case (s1_op_q)
            OP_ROL: carry = n_nz ? s1_a_q[idx_l] : 1'b0;
            OP_ROR: carry = n_nz ? s1_a_q[idx_r] : 1'b0;
            OP_SHL: carry = s1_sat_q ? s1_a_q[W-1] : (n_nz ? s1_a_q[idx_l] : 1'b0);
            OP_SHR: carry = s1_sat_q ? 1'b0        : (n_nz ? s1_a_q[idx_r] : 1'b0);
            OP_ASR: carry = s1_sat_q ? s1_a_q[W-1] : (n_nz ? s1_a_q[idx_r] : 1'b0);
            default: carry = 1'b0;
        endcase
    end
`endif

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_r_d     = s2_r_q;
`ifdef ALU_ROT_FLAGS_EN
        s2_c_d     = s2_c_q;
        s2_z_d     = s2_z_q;
`endif
        if (s2_en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_r_d = result;
`ifdef ALU_ROT_FLAGS_EN
                s2_c_d = carry;
                s2_z_d = (result == '0);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_op_q    <= '0;
            s1_n_q     <= '0;
            s1_sat_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_r_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_op_q    <= s1_op_d;
            s1_n_q     <= s1_n_d;
            s1_sat_q   <= s1_sat_d;
            s2_valid_q <= s2_valid_d;
            s2_r_q     <= s2_r_d;
        end
    end

`ifdef ALU_ROT_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_c_q <= 1'b0;
            s2_z_q <= 1'b0;
        end else begin
            s2_c_q <= s2_c_d;
            s2_z_q <= s2_z_d;
        end
    end

    assign out_c = s2_c_q;
    assign out_z = s2_z_q;
`endif

    assign out_valid = s2_valid_q;
    assign out_r     = s2_r_q;

endmodule

// File: tb/tb_alu_rot_pipe.sv
// Self-checking bench for alu_rot_pipe: directed vector table, streaming with
// backpressure, full throughput, mid-stall reset and a W=8/W=16 sweep.
module tb_alu_rot_pipe;
    import alu_rot_pkg::*;

    localparam int unsigned W = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_a, out_r;
    logic [2:0]   in_n;
    op_t          in_op;

    logic         v8, rdy8, ov8, v16, rdy16, ov16;
    logic [7:0]   a8, r8;
    logic [2:0]   n8;
    logic [15:0]  a16, r16;
    logic [3:0]   n16;
    op_t          op_s;
`ifdef ALU_ROT_FLAGS_EN
    logic out_c, out_z, c8, z8, c16, z16;
`endif

    int errors = 0;
    int checks = 0;

    alu_rot_pipe #(.W(7)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_n(in_n), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef ALU_ROT_FLAGS_EN
        .out_c(out_c), .out_z(out_z),
`endif
        .out_r(out_r));

    alu_rot_pipe #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8),
        .in_a(a8), .in_n(n8), .in_op(op_s), .out_valid(ov8),
        .out_ready(1'b1),
`ifdef ALU_ROT_FLAGS_EN
        .out_c(c8), .out_z(z8),
`endif
        .out_r(r8));

    alu_rot_pipe #(.W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16),
        .in_a(a16), .in_n(n16), .in_op(op_s), .out_valid(ov16),
        .out_ready(1'b1),
`ifdef ALU_ROT_FLAGS_EN
        .out_c(c16), .out_z(z16),
`endif
        .out_r(r16));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bit-serial reference: one single-position move per step.
    function automatic logic [31:0] model(input logic [31:0] a, input int unsigned n,
                                          input op_t op, input int unsigned w);
        logic [31:0] mask, r;
        logic        msb;
        int unsigned k;
        mask = (32'd1 << w) - 32'd1;
        r    = a & mask;
        msb  = r[w-1];
        case (op)
            OP_ROL: begin
                k = mod_w(n, w);
                repeat (k) r = ((r << 1) | (r >> (w - 1))) & mask;
            end
            OP_ROR: begin
                k = mod_w(n, w);
                repeat (k) r = ((r >> 1) | ((r & 32'd1) << (w - 1))) & mask;
            end
            OP_SHL: if (n >= w) r = '0; else repeat (n) r = (r << 1) & mask;
            OP_SHR: if (n >= w) r = '0; else repeat (n) r = r >> 1;
            OP_ASR: begin
                if (n >= w) r = msb ? mask : '0;
                else repeat (n) r = (r >> 1) | ({31'b0, msb} << (w - 1));
            end
            default: r = a & mask;
        endcase
        return r;
    endfunction

    typedef struct {
        op_t        op;
        logic [6:0] a;
        logic [2:0] n;
        logic [6:0] r;
        logic       c;
    } vec_t;

    vec_t vt[14];

    task automatic run_stream(input int nb, input int stall_lo, input int stall_hi,
                              output int first_out, output int last_out);
        logic [W-1:0] a_arr[32];
        logic [2:0]   n_arr[32];
        op_t          op_arr[32];
        logic [W-1:0] exp_arr[32];
        int sent = 0, recv = 0, cyc = 0;
        logic prev_stall = 1'b0, saw_block = 1'b0, fire_in, fire_out;
        logic [W-1:0] prev_r = '0;
        first_out = -1;
        last_out  = -1;
        for (int i = 0; i < nb; i++) begin
            a_arr[i]   = W'($urandom);
            n_arr[i]   = 3'($urandom_range(0, 7));
            op_arr[i]  = 3'($urandom_range(0, 5));
            exp_arr[i] = W'(model(32'(a_arr[i]), n_arr[i], op_arr[i], W));
        end
        while (recv < nb && cyc < 200) begin
            @(negedge clk);
            cyc++;
            out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
            in_valid  = (sent < nb);
            if (sent < nb) begin
                in_a  = a_arr[sent];
                in_n  = n_arr[sent];
                in_op = op_arr[sent];
            end
            #1;
            if (prev_stall) begin
                check("stall_hold_valid", 32'(out_valid), 32'd1);
                check("stall_hold_r", 32'(out_r), 32'(prev_r));
            end
            check("in_ready_chain", 32'(in_ready), 32'(((sent - recv) < 2) || out_ready));
            if (!in_ready) saw_block = 1'b1;
            fire_out = out_valid && out_ready;
            fire_in  = in_valid && in_ready;
            if (fire_out) begin
                check("stream_order", 32'(out_r), 32'(exp_arr[recv]));
                if (recv == 0) first_out = cyc;
                last_out = cyc;
                recv++;
            end
            if (fire_in) sent++;
            prev_stall = out_valid && !out_ready;
            prev_r     = out_r;
        end
        check("stream_count", 32'(recv), 32'(nb));
        check("backpressure_seen", 32'(saw_block), 32'(stall_hi >= stall_lo));
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("no_extra_beat", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int f, l;
        vt[0]  = '{OP_ROL, 7'b1000001, 3'd1, 7'b0000011, 1'b1};
        vt[1]  = '{OP_ROL, 7'b1000001, 3'd6, 7'b1100000, 1'b0};
        vt[2]  = '{OP_ROL, 7'b1011001, 3'd7, 7'b1011001, 1'b0};
        vt[3]  = '{OP_ASR, 7'b1000000, 3'd3, 7'b1111000, 1'b0};
        vt[4]  = '{OP_SHR, 7'b1111111, 3'd7, 7'b0000000, 1'b0};
        vt[5]  = '{OP_ROR, 7'b0000001, 3'd1, 7'b1000000, 1'b1};
        vt[6]  = '{3'd6,   7'b1010101, 3'd3, 7'b1010101, 1'b0};
        vt[7]  = '{OP_SHL, 7'b0000111, 3'd2, 7'b0011100, 1'b0};
        vt[8]  = '{OP_SHL, 7'b1010101, 3'd0, 7'b1010101, 1'b0};
        vt[9]  = '{OP_ASR, 7'b1111111, 3'd7, 7'b1111111, 1'b1};
        vt[10] = '{OP_ROR, 7'b1000001, 3'd7, 7'b1000001, 1'b0};
        vt[11] = '{OP_SHR, 7'b1100000, 3'd5, 7'b0000011, 1'b0};
        vt[12] = '{OP_ASR, 7'b0111111, 3'd2, 7'b0001111, 1'b1};
        vt[13] = '{OP_SHL, 7'b1111111, 3'd7, 7'b0000000, 1'b1};

        in_valid = 1'b0; in_a = '0; in_n = '0; in_op = OP_ROL; out_ready = 1'b1;
        v8 = 1'b0; v16 = 1'b0; a8 = '0; a16 = '0; n8 = '0; n16 = '0; op_s = OP_ROL;
        repeat (2) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_r", 32'(out_r), 32'd0);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = vt[i].a; in_n = vt[i].n; in_op = vt[i].op;
            #1;
            check("vec_accept", 32'(in_ready), 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            check("vec_latency_not_early", 32'(out_valid), 32'd0);
            @(negedge clk);
            check("vec_out_valid", 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_out_r", i), 32'(out_r), 32'(vt[i].r));
`ifdef ALU_ROT_FLAGS_EN
            check($sformatf("vec%0d_out_c", i), 32'(out_c), 32'(vt[i].c));
            check($sformatf("vec%0d_out_z", i), 32'(out_z), 32'(vt[i].r == 7'd0));
`endif
        end

        run_stream(10, 3, 6, f, l);
        run_stream(20, 0, -1, f, l);
        check("throughput_first", 32'(f), 32'd3);
        check("throughput_last", 32'(l), 32'd22);

        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 7'h55; in_n = 3'd1; in_op = OP_ROL;
        @(negedge clk);
        in_a = 7'h2a;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_out_r", 32'(out_r), 32'd0);
`ifdef ALU_ROT_FLAGS_EN
        check("async_rst_out_c", 32'(out_c), 32'd0);
        check("async_rst_out_z", 32'(out_z), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale_beat", 32'(out_valid), 32'd0);
        end

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            op_s = 3'(i % 5);
            a8   = 8'($urandom);
            a16  = 16'($urandom);
            if (i % 2 == 1) begin
                a8[7]   = 1'b1;
                a16[15] = 1'b1;
            end
            n8  = 3'(7 - (i % 8));
            n16 = 4'(15 - i);
            v8 = 1'b1; v16 = 1'b1;
            @(negedge clk);
            v8 = 1'b0; v16 = 1'b0;
            @(negedge clk);
            check("w8_valid", 32'(ov8), 32'd1);
            check($sformatf("w8_r op%0d n%0d", op_s, n8), 32'(r8), model(32'(a8), n8, op_s, 8));
            check("w16_valid", 32'(ov16), 32'd1);
            check($sformatf("w16_r op%0d n%0d", op_s, n16), 32'(r16), model(32'(a16), n16, op_s, 16));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_rot_pipe.md
Name: alu_rot_pipe

Overview:
- Parametrised, pipelined successor to the 7-bit combinational ROL unit in the ALU datapath.
- Supports operand width W and five modes: ROL, ROR, SHL, SHR, ASR.
- Uses a valid/ready handshake with full backpressure and a fixed 2-cycle latency.
- Sits between the ALU operand mux and the result writeback stage.

Parameters:
- W, 7, operand/result width in bits; legal for W >= 2.
- NW, $clog2(W), width of the shift/rotate amount. Derived; not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  W  operand.
- in_n  in  NW  shift/rotate amount.
- in_op  in  3  mode, encoded as in alu_rot_pkg.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_r  out  W  result.

Behaviour:
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Pipeline, two register stages S1 and S2, each with its own valid bit.
  - S1 captures in_a, in_op, and an effective amount n_eff.
  - S2 captures the barrel result.
- Latency: a beat accepted at edge k is presented on out_r/out_valid after edge k+1, i.e. 2 cycles with no stall.
- Throughput: 1 beat per cycle while out_ready=1.
- Ready chaining:
  - s2_en = !s2_valid || out_ready.
  - s1_en = !s1_valid || s2_en.
  - in_ready = s1_en.
  - in_ready is combinational from out_ready; there is no skid buffer.
- A stalled stage holds its data and valid bit unchanged.
- Simultaneous accept and drain on the same edge is legal and must not drop or duplicate a beat.
- n_eff computed at S1 capture:
  - Rotate modes: n_eff = in_n mod W (e.g. W=7, n=7 gives 0).
  - Shift modes: if in_n >= W, set a saturate flag instead.
- Result computed S1 to S2 as a logarithmic barrel of NW conditional stages. Stage k moves by 2^k when n_eff[k]=1.
- Mode semantics:
  - ROL: bits leaving the MSB re-enter at the LSB.
  - ROR: the mirror of ROL.
  - SHL/SHR: zero fill. Saturated result is all zeros.
  - ASR: fill with A[W-1]. Saturated result is W copies of A[W-1].
- n = 0 in any mode gives out_r = in_a.
- Reserved op codes (5-7) pass in_a through unchanged; no error is flagged.
- Reset: asserting rst_n low at any time, including mid-stall, clears:
  - s1_valid and s2_valid to 0, so out_valid=0.
  - out_r to 0 and all data registers to 0.
  - in_ready goes to 1 as soon as reset releases.
- In-flight beats are discarded on reset.
- While out_valid=1 && out_ready=0, out_r must stay stable.

Optional Feature:
- Macro: ALU_ROT_FLAGS_EN.
- When defined, adds two outputs aligned with out_r:
  - out_c, 1 bit: the last bit moved out.
    - ROL/SHL: A[W-n].
    - ROR/SHR/ASR: A[n-1].
    - Shift saturate: A[W-1] for SHL, 0 for SHR, A[W-1] for ASR.
    - 0 when n = 0 or the op is reserved.
  - out_z, 1 bit: out_r == 0.
- Both flags reset to 0 and are registered in S2.
- When not defined: the ports and registers do not exist, and behaviour is otherwise identical.

Decomposition:
- Package alu_rot_pkg contains:
  - Op encoding constants: OP_ROL=0, OP_ROR=1, OP_SHL=2, OP_SHR=3, OP_ASR=4.
  - A mod-W reduction function, shared with the verification model.
- Sub-module alu_rot_stage: one conditional barrel stage, parametrised by W and DIST = 2^k.
  - Inputs: data, enable, op, fill bit. Output: data.
  - Instantiated NW times via generate.

Test Plan:
- Rotate-left cases, W=7:
  - ROL, a=7'b1000001, n=1 -> out_r=7'b0000011 two cycles later (out_c=1 if flags enabled).
  - ROL, a=7'b1000001, n=6 -> out_r=7'b1100000.
  - ROL, n=7 -> out_r=a (mod-W wrap).
- Shift and mode cases, W=7:
  - ASR, a=7'b1000000, n=3 -> 7'b1111000.
  - SHR, a=7'b1111111, n=7 -> 7'b0000000.
  - ROR, a=7'b0000001, n=1 -> 7'b1000000.
  - Reserved op 6 -> out_r=a.
- Backpressure: stream 10 random beats with out_ready=0 for cycles 3-6.
  - in_ready deasserts once both stages are full.
  - out_r holds stable while stalled.
  - All 10 results arrive in order, none lost or duplicated.
- Full throughput: out_ready=1, in_valid=1 for 20 cycles -> 20 results on consecutive cycles after the 2-cycle latency.
- Mid-stall reset: assert rst_n=0 with both stages full.
  - out_valid=0 and out_r=0 immediately (asynchronous).
  - in_ready=1 after release.
  - No stale beat emerges.
- Parameter sweep: repeat the rotate and shift cases for W=8 and W=16 against the package reference model.
